// File: rtl/mac_pkg.sv
// Shared constants for the FIFO-fed multiply-accumulate stage.
// FSM encoding and default widths used by every block in the slice.
package mac_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FILT_LEN   = 4;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_CNT_WIDTH  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/weight_regfile.sv
// Filter weight storage: one write port, combinational read.
// Cleared by reset only; clear/abort leaves weights intact.
module weight_regfile
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FILT_LEN   = DEF_FILT_LEN,
    parameter int AW         = $clog2(FILT_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FILT_LEN];

    // Weight writes; addresses past the last tap are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FILT_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < FILT_LEN)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_mac_stage.sv
// FIFO-to-FIFO FIR window engine: reads FILT_LEN samples per window,
// accumulates sample*weight, and pushes one sum per window downstream.
module fifo_mac_stage
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FILT_LEN   = DEF_FILT_LEN,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        num_windows,
    input  logic                        w_wen,
    input  logic [$clog2(FILT_LEN)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]       w_din,
    input  logic                        in_empty,
    input  logic [DATA_WIDTH-1:0]       in_dout,
    output logic                        in_ren,
    input  logic                        out_full,
    output logic [ACC_WIDTH-1:0]        out_din,
    output logic                        out_wen,
    output logic                        busy,
    output logic                        done
);

    localparam int KW = $clog2(FILT_LEN);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(FILT_LEN - 1);

    logic [1:0]                   state;
    logic [1:0]                   state_nxt;
    logic [KW-1:0]                k;
    logic [CNT_WIDTH-1:0]         win_cnt;
    logic [CNT_WIDTH-1:0]         win_inc;
    logic [CNT_WIDTH-1:0]         num_lat;
    logic [ACC_WIDTH-1:0]         acc;
    logic [ACC_WIDTH-1:0]         acc_sum;
    logic [ACC_WIDTH-1:0]         result;
    logic [DATA_WIDTH-1:0]        wt_raw;
    logic signed [DATA_WIDTH-1:0] wt_k;
    logic signed [DATA_WIDTH-1:0] smp;
    logic signed [PW-1:0]         prod;
    logic                         last_tap;
    logic                         last_win;
    logic                         w_we;

    // Weights are only writable between jobs
    assign w_we = w_wen && (state == ST_IDLE);

    weight_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .FILT_LEN   (FILT_LEN),
        .AW         (KW)
    ) u_wrf (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_addr),
        .wdata (w_din),
        .raddr (k),
        .rdata (wt_raw)
    );

    assign wt_k = wt_raw;
    assign smp  = in_dout;

    // Full-precision signed product, then sign-extended into the acc
    assign prod    = PW'(smp) * PW'(wt_k);
    assign acc_sum = acc + ACC_WIDTH'(prod);

    assign last_tap = (k == K_LAST);
    assign win_inc  = win_cnt + CNT_WIDTH'(1);
    assign last_win = (win_inc == num_lat);

    // Clear masks both FIFO strobes so an abort never moves data
    assign in_ren  = (state == ST_ACCUM) && !in_empty && !clear;
    assign out_wen = (state == ST_WRITE) && !out_full && !clear;
    assign out_din = result;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // Next-state decode; clear overrides every transition
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = (num_windows == '0) ? ST_DONE
                                                        : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_ren && last_tap) begin
                        state_nxt = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (out_wen) begin
                        state_nxt = last_win ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tap/window counters, accumulator and result holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            win_cnt <= '0;
            num_lat <= '0;
            acc     <= '0;
            result  <= '0;
        end else if (clear) begin
            k       <= '0;
            win_cnt <= '0;
            acc     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_lat <= num_windows;
                        k       <= '0;
                        win_cnt <= '0;
                        acc     <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (in_ren) begin
                        if (last_tap) begin
                            result <= acc_sum;
                            acc    <= '0;
                            k      <= '0;
                        end else begin
                            acc <= acc_sum;
                            k   <= k + KW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (out_wen) begin
                        win_cnt <= win_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_mac_stage.sv
// Self-checking bench for fifo_mac_stage against a queue-based
// FIFO model and a plain-arithmetic dot-product reference.
module tb_fifo_mac_stage;

    localparam int DW  = 16;
    localparam int F   = 4;
    localparam int AWD = 40;
    localparam int CW  = 8;
    localparam int KW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           start;
    logic [CW-1:0]  num_windows;
    logic           w_wen;
    logic [KW-1:0]  w_addr;
    logic [DW-1:0]  w_din;
    logic           in_empty;
    logic [DW-1:0]  in_dout;
    logic           in_ren;
    logic           out_full;
    logic [AWD-1:0] out_din;
    logic           out_wen;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    logic signed [DW-1:0] wt [F];
    logic [DW-1:0]        sq [$];
    logic [AWD-1:0]       exp_q [$];

    fifo_mac_stage #(
        .DATA_WIDTH (DW),
        .FILT_LEN   (F),
        .ACC_WIDTH  (AWD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .start       (start),
        .num_windows (num_windows),
        .w_wen       (w_wen),
        .w_addr      (w_addr),
        .w_din       (w_din),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .in_ren      (in_ren),
        .out_full    (out_full),
        .out_din     (out_din),
        .out_wen     (out_wen),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference: each window is the dot product of F samples with weights
    task automatic build_expected(input int nwin);
        longint s;
        exp_q.delete();
        for (int w = 0; w < nwin; w++) begin
            s = 0;
            for (int t = 0; t < F; t++) begin
                s += longint'(wt[t]) * longint'($signed(sq[w*F+t]));
            end
            exp_q.push_back(AWD'(s));
        end
    endtask

    task automatic load_weights();
        for (int t = 0; t < F; t++) begin
            w_wen  = 1'b1;
            w_addr = KW'(t);
            w_din  = wt[t];
            @(posedge clk); #1;
        end
        w_wen = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) sq.push_back(DW'($urandom));
    endtask

    task automatic rand_weights();
        for (int t = 0; t < F; t++) wt[t] = DW'($urandom);
    endtask

    // emode: 0 never empty, 1 toggle, 2 random
    // fmode: 0 never full, 1 full over cycles 5..9, 2 random
    task automatic run_job(input int nwin, input int emode,
                           input int fmode, input bit poke,
                           output int wcyc, output int dcyc);
        int  reads;
        int  writes;
        int  dones;
        bit  fin;
        bit  pop;
        logic [AWD-1:0] e;
        reads = 0; writes = 0; dones = 0; fin = 0;
        wcyc = -1; dcyc = -1;
        build_expected(nwin);
        start       = 1'b1;
        num_windows = CW'(nwin);
        in_empty    = 1'b1;
        in_dout     = '0;
        out_full    = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            pop = 0;
            checks++;
            if (in_ren && out_wen) begin
                failures++;
                $display("FAIL ren_wen_overlap cycle=%0d", c);
            end
            if (in_ren) begin
                reads++;
                pop = 1;
            end
            if (out_wen) begin
                writes++;
                if (wcyc < 0) wcyc = c;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_write got=%0d req=none",
                             out_din);
                end else begin
                    e = exp_q.pop_front();
                    if (out_din !== e) begin
                        failures++;
                        $display("FAIL out_din got=%h req=%h",
                                 out_din, e);
                    end
                end
            end
            if (fmode == 1 && c >= 5 && c < 10) begin
                checks++;
                if (out_wen !== 1'b0 || exp_q.size() == 0 ||
                    out_din !== exp_q[0]) begin
                    failures++;
                    $display("FAIL hold cycle=%0d wen=%b din=%h",
                             c, out_wen, out_din);
                end
            end
            if (done) begin
                dones++;
                if (dcyc < 0) dcyc = c;
                fin = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            w_wen = 1'b0;
            if (pop && sq.size() > 0) void'(sq.pop_front());
            if (sq.size() == 0)  in_empty = 1'b1;
            else if (emode == 1) in_empty = (c % 2 == 0);
            else if (emode == 2) in_empty = ($urandom_range(0, 99) < 35);
            else                 in_empty = 1'b0;
            in_dout = (sq.size() > 0) ? sq[0] : '0;
            if (fmode == 1)      out_full = (c + 1 >= 5 && c + 1 < 10);
            else if (fmode == 2) out_full = ($urandom_range(0, 99) < 40);
            else                 out_full = 1'b0;
            if (poke && c == 1) begin
                start       = 1'b1;
                num_windows = CW'(9);
                w_wen       = 1'b1;
                w_addr      = '0;
                w_din       = ~wt[0];
            end
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL timeout no done within budget");
        end
        checks++;
        if (reads != nwin * F) begin
            failures++;
            $display("FAIL reads got=%0d req=%0d", reads, nwin * F);
        end
        checks++;
        if (writes != nwin || exp_q.size() != 0) begin
            failures++;
            $display("FAIL writes got=%0d req=%0d", writes, nwin);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL done_count got=%0d req=1", dones);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_job busy=%b done=%b req=0", busy, done);
        end
        in_empty = 1'b1;
        out_full = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({in_ren, out_wen, busy, done} !== 4'b0 || out_din !== '0) begin
            failures++;
            $display("FAIL reset_outputs ren=%b wen=%b busy=%b done=%b din=%h",
                     in_ren, out_wen, busy, done, out_din);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int wc;
        int dc;
        for (int t = 0; t < F; t++) wt[t] = DW'(t + 1);
        load_weights();
        sq.delete();
        for (int i = 0; i < F; i++) sq.push_back(DW'(1));
        run_job(1, 0, 0, 0, wc, dc);
        checks++;
        if (wc != 5) begin
            failures++;
            $display("FAIL write_latency got=%0d req=5", wc);
        end
        checks++;
        if (dc != 6) begin
            failures++;
            $display("FAIL done_latency got=%0d req=6", dc);
        end
    endtask

    task automatic test_neg();
        int wc;
        int dc;
        for (int t = 0; t < F; t++) wt[t] = -16'sd1;
        load_weights();
        sq.delete();
        for (int i = 0; i < F; i++) sq.push_back(DW'(32767));
        run_job(1, 0, 0, 0, wc, dc);
    endtask

    task automatic test_stall();
        int wc;
        int dc;
        rand_weights();
        load_weights();
        sq.delete();
        fill_rand(3 * F);
        run_job(3, 1, 0, 0, wc, dc);
    endtask

    task automatic test_backpressure();
        int wc;
        int dc;
        rand_weights();
        load_weights();
        sq.delete();
        fill_rand(F);
        run_job(1, 0, 1, 0, wc, dc);
        checks++;
        if (wc != 10) begin
            failures++;
            $display("FAIL release_write cycle got=%0d req=10", wc);
        end
    endtask

    task automatic test_clear();
        int wc;
        int dc;
        rand_weights();
        load_weights();
        sq.delete();
        in_empty    = 1'b0;
        in_dout     = DW'($urandom);
        start       = 1'b1;
        num_windows = CW'(1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            in_dout = DW'($urandom);
        end
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ren !== 1'b0 || out_wen !== 1'b0) begin
            failures++;
            $display("FAIL clear_cycle ren=%b wen=%b req=0", in_ren, out_wen);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_wen !== 1'b0 || in_ren !== 1'b0) begin
                failures++;
                $display("FAIL after_clear busy=%b wen=%b ren=%b req=0",
                         busy, out_wen, in_ren);
            end
        end
        @(posedge clk); #1;
        in_empty = 1'b1;
        fill_rand(F);
        run_job(1, 0, 0, 0, wc, dc);
    endtask

    task automatic test_busy_ignore();
        int wc;
        int dc;
        rand_weights();
        load_weights();
        sq.delete();
        fill_rand(2 * F);
        run_job(2, 0, 0, 1, wc, dc);
        fill_rand(F);
        run_job(1, 0, 0, 0, wc, dc);
    endtask

    task automatic test_zero();
        int wc;
        int dc;
        sq.delete();
        run_job(0, 0, 0, 0, wc, dc);
        checks++;
        if (dc != 1) begin
            failures++;
            $display("FAIL zero_win_done got=%0d req=1", dc);
        end
    endtask

    task automatic test_random();
        int wc;
        int dc;
        int n;
        for (int j = 0; j < 4; j++) begin
            rand_weights();
            load_weights();
            sq.delete();
            n = $urandom_range(1, 5);
            fill_rand(n * F);
            run_job(n, 2, 2, 0, wc, dc);
        end
    endtask

    task automatic test_rst_write();
        int wc;
        int dc;
        rand_weights();
        load_weights();
        sq.delete();
        in_empty    = 1'b0;
        out_full    = 1'b1;
        in_dout     = DW'($urandom);
        start       = 1'b1;
        num_windows = CW'(1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            in_dout = DW'($urandom);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_wen !== 1'b0) begin
            failures++;
            $display("FAIL write_hold busy=%b wen=%b", busy, out_wen);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ren, out_wen, busy, done} !== 4'b0 || out_din !== '0) begin
            failures++;
            $display("FAIL async_rst ren=%b wen=%b busy=%b done=%b din=%h",
                     in_ren, out_wen, busy, done, out_din);
        end
        out_full = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (in_ren !== 1'b0 || out_wen !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold ren=%b wen=%b req=0", in_ren, out_wen);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_empty = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < F; t++) wt[t] = '0;
        fill_rand(F);
        run_job(1, 0, 0, 0, wc, dc);
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        start       = 1'b0;
        num_windows = '0;
        w_wen       = 1'b0;
        w_addr      = '0;
        w_din       = '0;
        in_empty    = 1'b1;
        in_dout     = '0;
        out_full    = 1'b0;
        test_reset();
        test_basic();
        test_neg();
        test_stall();
        test_backpressure();
        test_clear();
        test_busy_ignore();
        test_zero();
        test_random();
        test_rst_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_mac_stage.md
FIFO_MAC_STAGE -- requirements
Module: fifo_mac_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample and weight bitwidth.
REQ-002 SHALL have parameter FILT_LEN, default 4, taps per window (2..16).
REQ-003 SHALL have parameter ACC_WIDTH, default 40, accumulator and result bitwidth.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, window-count bitwidth.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: clear  in  1  synchronous abort to IDLE.
REQ-008 SHALL have ports: start  in  1  begin a job; num_windows  in  CNT_WIDTH  windows per job, latched on start.
REQ-009 SHALL have ports: w_wen  in  1; w_addr  in  $clog2(FILT_LEN); w_din  in  DATA_WIDTH  weight load.
REQ-010 SHALL have ports: in_empty  in  1; in_dout  in  DATA_WIDTH; in_ren  out  1  upstream sample FIFO read side.
REQ-011 SHALL have ports: out_full  in  1; out_din  out  ACC_WIDTH; out_wen  out  1  downstream result FIFO write side.
REQ-012 SHALL have ports: busy  out  1; done  out  1  one-cycle job-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, WRITE, DONE.
REQ-014 IDLE: start=1 with num_windows>0 -> ACCUM, latch num_windows, zero tap counter k, window counter, accumulator; start with num_windows=0 -> DONE directly.
REQ-015 ACCUM: in_ren SHALL be combinational (state==ACCUM && !in_empty); in_dout valid in same cycle as in_ren.
REQ-016 ACCUM: each cycle with in_ren=1, acc <= acc + sext(in_dout*weight[k]), k <= k+1; in_empty=1 SHALL stall with acc and k held.
REQ-017 ACCUM: on the read where k==FILT_LEN-1, register final sum into result register and go WRITE.
REQ-018 WRITE: out_wen = (state==WRITE && !out_full), out_din = result register; SHALL stay in WRITE while out_full=1.
REQ-019 WRITE with out_wen=1: window counter +1; if new count==latched num_windows -> DONE, else -> ACCUM with acc and k zeroed.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 busy SHALL be 1 in ACCUM, WRITE, DONE; 0 in IDLE.
REQ-022 Multiply SHALL be signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, sign-extended to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH, no saturation.
REQ-023 Throughput with in_empty=0, out_full=0: FILT_LEN+1 cycles per window.
REQ-024 start while busy SHALL be ignored; w_wen while busy SHALL be ignored.
REQ-025 clear SHALL take priority over start and all FSM transitions: next state IDLE, counters/acc zeroed, weights kept; in_ren and out_wen SHALL be 0 in the clear cycle.
REQ-026 in_ren and out_wen SHALL never be asserted in the same cycle.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, k, window counter, acc, result register, and all weights to 0.
REQ-028 Output reset values: in_ren=0, out_wen=0, out_din=0, busy=0, done=0.
REQ-029 rst mid-job SHALL drop the job with no further FIFO reads or writes.

Structure
REQ-030 FSM state encoding and default parameter constants SHALL live in shared package mac_pkg.
REQ-031 Weight storage SHALL be sub-module weight_regfile (FILT_LEN x DATA_WIDTH, one write port, combinational read by k).

Verification
REQ-032 Weights {1,2,3,4}, samples {1,1,1,1}, num_windows=1, no stalls -> out_din=10 with out_wen 5 cycles after start, done next cycle.
REQ-033 Weights {-1,-1,-1,-1}, samples {32767 x4} -> out_din=-131068 sign-extended to 40 bits.
REQ-034 num_windows=3, in_empty toggling every other cycle -> exactly 12 in_ren pulses, 3 out_wen pulses, correct sums.
REQ-035 out_full held 1 for 5 cycles in WRITE -> out_wen=0 and out_din stable throughout, single write after release.
REQ-036 clear asserted mid-ACCUM at k=2 -> IDLE next cycle, no out_wen; new start recomputes correctly from zero.
REQ-037 rst asserted mid-WRITE -> all outputs 0 immediately (asynchronously); weights 0 after release.
